// File: rtl/scan_mux_n_pkg.sv
// Shared types for the scanning N-channel mux.
// Scan FSM states and select-mode encodings.
package mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } scan_state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_n_if.sv
// Data/handshake bundle for scan_mux_n.
// master = source/consumer side, slave = mux side.
interface scan_mux_n_if #(
  parameter int CH = 8,
  parameter int W  = 1
);
  localparam int SEL_W = $clog2(CH);

  logic [CH*W-1:0]  din;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             out_ready;
  logic [W-1:0]     dout;
  logic             out_valid;
  logic [SEL_W-1:0] cur_ch;
  logic             frame_done;

  modport master (
    output din, mode, sel, en, out_ready,
    input  dout, out_valid, cur_ch, frame_done
  );

  modport slave (
    input  din, mode, sel, en, out_ready,
    output dout, out_valid, cur_ch, frame_done
  );

endinterface

// File: rtl/scan_mux_n_sel.sv
// Combinational CH:1 channel select.
// Indices past the last channel yield zero.
module mux_sel_n #(
  parameter  int CH    = 8,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(CH)
) (
  input  logic [CH*W-1:0]  din_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic [W-1:0]     q_o
);

  always_comb begin
    q_o = '0;
    for (int k = 0; k < CH; k++) begin
      if (idx_i == SEL_W'(k)) q_o = din_i[k*W +: W];
    end
  end

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-channel mux, manual or auto-scan select,
// with a valid/ready output stage.
module scan_mux_n
  import mux_pkg::*;
#(
  parameter int CH    = 8,
  parameter int W     = 1,
  parameter int DWELL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  scan_mux_n_if.slave  bus
);

  localparam int SEL_W = $clog2(CH);
  localparam int DW_W  = $clog2(DWELL + 1);

  localparam logic [SEL_W-1:0] LAST    = SEL_W'(CH - 1);
  localparam logic [DW_W-1:0]  DW_LOAD = DW_W'(DWELL - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] scan_q, scan_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;

  logic             cap_ok;
  logic             scan_on;
  logic             take_m;
  logic             take_s;
  logic [SEL_W-1:0] idx;
  logic [W-1:0]     pick;

  assign cap_ok  = bus.en && (!valid_q || bus.out_ready);
  assign scan_on = (bus.mode == MODE_SCAN) && bus.en;
  assign take_m  = (bus.mode == MODE_MANUAL) && cap_ok;
  assign idx     = (bus.mode == MODE_SCAN) ? scan_q : bus.sel;

  mux_sel_n #(
    .CH (CH),
    .W  (W)
  ) u_sel (
    .din_i (bus.din),
    .idx_i (idx),
    .q_o   (pick)
  );

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    dwell_d = dwell_q;
    take_s  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_on) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cap_ok) begin
          take_s = 1'b1;
          scan_d = (scan_q == LAST) ? '0 : scan_q + SEL_W'(1);
          if (DWELL > 1) begin
            state_d = WAIT;
            dwell_d = DW_LOAD;
          end
        end
      end
      WAIT: begin
        dwell_d = dwell_q - DW_W'(1);
        if (dwell_q <= DW_W'(1)) state_d = CAPTURE;
      end
      default: state_d = IDLE;
    endcase
    // leaving scan (manual or disabled) restarts the next scan at ch 0
    if (!scan_on) begin
      state_d = IDLE;
      scan_d  = '0;
      dwell_d = '0;
      take_s  = 1'b0;
    end
  end

  always_comb begin
    dout_d  = dout_q;
    cur_d   = cur_q;
    frame_d = frame_q;
    valid_d = valid_q;
    if (valid_q && bus.out_ready) valid_d = 1'b0;
    if (take_m) begin
      dout_d  = pick;
      cur_d   = bus.sel;
      frame_d = 1'b0;
      valid_d = 1'b1;
    end else if (take_s) begin
      dout_d  = pick;
      cur_d   = scan_q;
      frame_d = (scan_q == LAST);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scan_q  <= '0;
      dwell_q <= '0;
      cur_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      dwell_q <= dwell_d;
      cur_q   <= cur_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.out_valid  = valid_q;
  assign bus.cur_ch     = cur_q;
  assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Bench for scan_mux_n: directed steps plus random traffic,
// every cycle compared against a behavioural model.
module tb_scan_mux_n;
  import mux_pkg::*;

  localparam int CH    = 8;
  localparam int W     = 4;
  localparam int DWELL = 3;
  localparam int SEL_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan_mux_n_if #(.CH(CH), .W(W)) bus ();

  scan_mux_n #(
    .CH    (CH),
    .W     (W),
    .DWELL (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0]     e_dout;
  logic             e_valid;
  logic [SEL_W-1:0] e_cur;
  logic             e_frame;
  bit               m_active;
  int               m_ch;
  int               m_since;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] chan(int k);
    logic [CH*W-1:0] d;
    d = bus.din;
    if (k >= CH) return '0;
    return d[k*W +: W];
  endfunction

  // Model: a scan capture needs scan mode active since the previous cycle
  // and at least DWELL cycles since the previous scan capture.
  task automatic cyc();
    bit ok;
    bit cs;
    ok = bus.en && (!e_valid || bus.out_ready);
    cs = 1'b0;
    if (!rst_n) begin
      e_dout = '0; e_valid = 1'b0; e_cur = '0; e_frame = 1'b0;
      m_active = 1'b0; m_ch = 0; m_since = DWELL;
    end else begin
      if (e_valid && bus.out_ready) e_valid = 1'b0;
      if (bus.mode == MODE_MANUAL) begin
        if (ok) begin
          e_dout = chan(int'(bus.sel)); e_cur = bus.sel;
          e_frame = 1'b0; e_valid = 1'b1;
        end
      end else if (m_active && m_since >= DWELL && ok) begin
        e_dout = chan(m_ch); e_cur = SEL_W'(m_ch);
        e_frame = (m_ch == CH - 1); e_valid = 1'b1; cs = 1'b1;
      end
      if (bus.mode == MODE_SCAN && bus.en) begin
        m_active = 1'b1;
        if (cs) begin
          m_ch = (m_ch + 1) % CH; m_since = 1;
        end else if (m_since < DWELL) m_since++;
      end else begin
        m_active = 1'b0; m_ch = 0; m_since = DWELL;
      end
    end
    @(posedge clk);
    #1;
    chk("model_valid", 32'(bus.out_valid), 32'(e_valid));
    if (e_valid) begin
      chk("model_dout", 32'(bus.dout), 32'(e_dout));
      chk("model_cur", 32'(bus.cur_ch), 32'(e_cur));
      chk("model_frame", 32'(bus.frame_done), 32'(e_frame));
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < CH; k++) bus.din[k*W +: W] = W'(k + 1);
  endtask

  task automatic wait_scan(int ch);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (bus.out_valid && int'(bus.cur_ch) == ch) found = 1'b1;
    end
    chk("wait_scan_ch", 32'(found), 32'(1));
  endtask

  initial begin
    int ncap;
    int last;
    bus.din = '0; bus.mode = MODE_MANUAL; bus.sel = '0;
    bus.en = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_dout", 32'(bus.dout), 32'(0));
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_cur", 32'(bus.cur_ch), 32'(0));
    chk("rst_frame", 32'(bus.frame_done), 32'(0));
    rst_n = 1'b1;

    // manual sweep
    set_ramp();
    bus.en = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      bus.sel = SEL_W'(i);
      cyc();
      chk("man_dout", 32'(bus.dout), 32'(i + 1));
      chk("man_cur", 32'(bus.cur_ch), 32'(i));
      chk("man_valid", 32'(bus.out_valid), 32'(1));
      chk("man_frame", 32'(bus.frame_done), 32'(0));
    end

    // backpressure hold
    bus.sel = 3'd3;
    cyc();
    chk("bp_dout", 32'(bus.dout), 32'(4));
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sel = 3'd5;
      bus.din = $urandom();
      cyc();
      chk("bp_hold_dout", 32'(bus.dout), 32'(4));
      chk("bp_hold_cur", 32'(bus.cur_ch), 32'(3));
      chk("bp_hold_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_next_cur", 32'(bus.cur_ch), 32'(5));

    // auto-scan with dwell
    set_ramp();
    bus.mode = MODE_SCAN;
    ncap = 0;
    last = 0;
    for (int i = 0; i < 60 && ncap < 9; i++) begin
      cyc();
      if (bus.out_valid) begin
        chk("scan_cur", 32'(bus.cur_ch), 32'(ncap % CH));
        chk("scan_frame", 32'(bus.frame_done), 32'((ncap % CH) == CH - 1));
        if (ncap > 0) chk("scan_gap", 32'(i - last), 32'(DWELL));
        last = i;
        ncap++;
      end
    end
    chk("scan_count", 32'(ncap), 32'(9));

    // scan stall after ch 2
    wait_scan(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("stall_cur", 32'(bus.cur_ch), 32'(2));
      chk("stall_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("stall_resume_cur", 32'(bus.cur_ch), 32'(3));
    chk("stall_resume_dout", 32'(bus.dout), 32'(4));

    // mode switch at ch 5, then back to scan
    wait_scan(5);
    bus.mode = MODE_MANUAL; bus.sel = 3'd1;
    cyc();
    chk("sw_man_cur", 32'(bus.cur_ch), 32'(1));
    chk("sw_man_dout", 32'(bus.dout), 32'(2));
    bus.mode = MODE_SCAN;
    cyc();
    chk("sw_idle_valid", 32'(bus.out_valid), 32'(0));
    cyc();
    chk("sw_restart_cur", 32'(bus.cur_ch), 32'(0));
    chk("sw_restart_dout", 32'(bus.dout), 32'(1));
    chk("sw_restart_valid", 32'(bus.out_valid), 32'(1));

    // reset while a sample is pending
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_dout", 32'(bus.dout), 32'(0));
    chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
    chk("mid_rst_cur", 32'(bus.cur_ch), 32'(0));
    chk("mid_rst_frame", 32'(bus.frame_done), 32'(0));
    rst_n = 1'b1;

    // disable with pending data
    bus.mode = MODE_MANUAL; bus.sel = 3'd6;
    cyc();
    chk("dis_dout", 32'(bus.dout), 32'(7));
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("dis_hold_dout", 32'(bus.dout), 32'(7));
      chk("dis_hold_valid", 32'(bus.out_valid), 32'(1));
    end
    bus.out_ready = 1'b1;
    cyc();
    chk("dis_drain_valid", 32'(bus.out_valid), 32'(0));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(199) != 0);
      if ($urandom_range(15) == 0) bus.mode = ~bus.mode;
      bus.en = ($urandom_range(31) != 0);
      bus.out_ready = ($urandom_range(9) < 7);
      bus.sel = SEL_W'($urandom());
      bus.din = $urandom();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_mux_n.md
Name: scan_mux_n

Overview:
- Parametrised, registered N-channel multiplexer with a valid/ready output handshake.
- Two select modes:
  - manual: the external select chooses the channel.
  - auto-scan: an internal counter walks channels 0..CH-1 and waits a programmable dwell time between captures.
- Sits between sensor/data sources and a serial consumer, which sees one channel sample per transfer.

Parameters:
- CH, 8, number of input channels (>=2).
- W, 1, bit width of each channel.
- DWELL, 1, minimum clock cycles between successive scan-mode captures (>=1).
- SEL_W, $clog2(CH), localparam, select/counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  CH*W  packed channels; channel k occupies din[k*W +: W].
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SEL_W  channel select, used in manual mode only.
- en  in  1  capture enable.
- out_ready  in  1  consumer accepts dout this cycle.
- dout  out  W  registered selected sample.
- out_valid  out  1  dout holds an unconsumed sample.
- cur_ch  out  SEL_W  channel index of the sample in dout.
- frame_done  out  1  high while dout holds a scan-mode sample of channel CH-1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- While rst_n=0 at a clk edge, all outputs and internal state clear:
  - dout=0, out_valid=0, cur_ch=0, frame_done=0.
  - scan counter=0, dwell counter=0, state=IDLE.
- A reset mid-transfer discards the pending sample.
- Transfer: occurs on a cycle with out_valid && out_ready.
- Capture opportunity: `cap_ok = en && (!out_valid || out_ready)`.
  - A captured sample appears on dout with out_valid=1 on the next edge, so latency is 1 cycle.
  - Back-to-back captures are possible (full throughput in manual mode).
- Hold rule: while out_valid=1 and out_ready=0, dout, cur_ch and frame_done are frozen.
  - Changes on din, sel or mode do not alter them.
- out_valid clearing: out_valid falls after a transfer with no simultaneous capture.
- en=0 with data pending: the pending sample stays valid until accepted.
- Manual mode (mode=0):
  - On cap_ok, dout <= din[sel], cur_ch <= sel, frame_done <= 0.
  - If sel >= CH (non-power-of-2 CH), dout <= 0 and cur_ch <= sel.
- Scan FSM (mode=1), states IDLE, WAIT, CAPTURE:
  - IDLE: entered on reset or when mode=0 or en=0. Scan counter and dwell counter are cleared on entry. Goes to CAPTURE when mode=1 && en=1.
  - CAPTURE:
    - On cap_ok: dout <= din[scan_cnt], cur_ch <= scan_cnt, frame_done <= (scan_cnt==CH-1).
    - scan_cnt then advances, wrapping CH-1 -> 0.
    - If DWELL==1, stay in CAPTURE; else go to WAIT with dwell counter = DWELL-1.
    - If cap_ok=0 (consumer stalled), stay in CAPTURE with no capture. The dwell timer does not run.
  - WAIT: dwell counter decrements each cycle regardless of out_ready. At 1 it goes to CAPTURE.
  - Captures in scan mode are therefore spaced at least DWELL cycles apart.
- Mode change: mode 1->0 mid-scan returns the FSM to IDLE and restarts the scan at channel 0 on the next entry. The pending sample is preserved.
- Widths:
  - The dwell counter is $clog2(DWELL+1) bits.
  - No arithmetic on data; W bits pass through unchanged.

Decomposition:
- Shared package `mux_pkg`:
  - scan-state enum (IDLE, WAIT, CAPTURE).
  - mode encodings MODE_MANUAL=0, MODE_SCAN=1.
- One natural sub-module `mux_sel_n` (purely combinational CH:1 W-bit select with out-of-range -> 0).
- Registers, handshake and FSM stay in `scan_mux_n`.

Test Plan:
1. Reset and manual mode:
   - Stimulus: CH=8, W=4, mode=0, out_ready=1, en=1; din channels k=k+1; sel sweeps 0..7 one per cycle.
   - Response: dout = 1..8 each one cycle later, cur_ch matches, out_valid stays 1, frame_done=0.
2. Backpressure hold:
   - Stimulus: manual, sel=3, capture; then out_ready=0 for 5 cycles while sel changes to 5 and din changes.
   - Response: dout=4 and cur_ch=3 are held with out_valid=1. After out_ready=1, the next sample is channel 5.
3. Auto-scan with dwell:
   - Stimulus: DWELL=3, mode=1, en=1, out_ready=1.
   - Response: captures every 3 cycles with cur_ch 0,1,..,7,0. frame_done=1 only with cur_ch=7, then wrap to 0.
4. Scan stall:
   - Stimulus: scan mode, out_ready=0 after capturing ch 2.
   - Response: no further capture, the scan counter holds at 3. The channel-3 capture occurs once the consumer is ready; ch 3 is not skipped.
5. Mode switch and reset mid-operation:
   - Stimulus: switch to manual at cur_ch=5, then back to scan.
   - Response: the scan restarts at ch 0.
   - Stimulus: rst_n=0 for one edge while out_valid=1.
   - Response: all outputs are 0 on the next edge.
6. Disable with pending data:
   - Stimulus: en drops while out_valid=1 and out_ready=0.
   - Response: the sample persists. It is consumed once out_ready=1, then out_valid=0.
